startup_display_datapath: RTL and testbench

- Datapath and LED driver under the startup-display control FSM.
- Supplies the FSM's TMR and DONE inputs.
- Acts on its CLEAR, DISP, LOAD_PAT, NXT_ADR and RST_TMR strobes: pattern timer, pattern address counter, built-in pattern table and pattern register.
- Drives the front-panel LEDs in parallel, and serially to an external LED shift register with a latch pulse.

---
 rtl/startup_display_datapath_if.sv | 29 ++
 rtl/startup_display_datapath.sv | 175 +++++++++++++++++
 tb/tb_startup_display_datapath.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/startup_display_datapath_if.sv
// Strobe/status bundle between the startup-display control FSM and its datapath.
// The FSM (or a bench standing in for it) uses master; the datapath uses slave.
interface startup_display_datapath_if #(
  parameter int TMR_W = 16,
  parameter int LED_W = 8
);
  logic             CLEAR;
  logic             DISP;
  logic             LOAD_PAT;
  logic             NXT_ADR;
  logic             RST_TMR;
  logic [TMR_W-1:0] TMR;
  logic             DONE;
  logic [LED_W-1:0] LED;
  logic             SCLK;
  logic             SDATA;
  logic             SLATCH;
  logic             BUSY;

  modport master (
    output CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR,
    input  TMR, DONE, LED, SCLK, SDATA, SLATCH, BUSY
  );

  modport slave (
    input  CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR,
    output TMR, DONE, LED, SCLK, SDATA, SLATCH, BUSY
  );
endinterface

// File: rtl/startup_display_datapath.sv
// Startup-display datapath: dwell timer, pattern address/table/register, and the
// LED driver (parallel register plus serial shift-out with latch strobe).
module startup_display_datapath #(
  parameter int TMR_W    = 16,
  parameter int NPAT     = 16,
  parameter int ADR_W    = 4,
  parameter int LED_W    = 8,
  parameter int SCLK_DIV = 4
) (
  input logic                      CLK,
  input logic                      RST_B,
  startup_display_datapath_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W = $clog2(LED_W + 1);

  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(NPAT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  // Walking-one table: entry i lights LED (i mod LED_W).
  function automatic logic [LED_W-1:0] pat_entry(input logic [ADR_W-1:0] a);
    logic [31:0] idx;
    idx = 32'(a) % 32'(LED_W);
    return {{(LED_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       st_q, st_d;
  logic             sclk_q, sclk_d;
  logic             slatch_q, slatch_d;
  logic             busy_q, busy_d;
  logic             pend_q, pend_d;
  logic             upd_s;

  // Timer, address, pattern register and parallel LED next-state.
  always_comb begin
    tmr_d = tmr_q;
    adr_d = adr_q;
    pat_d = pat_q;
    if (bus.RST_TMR) begin
      tmr_d = '0;
    end else if (tmr_q != TMR_MAX) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = tmr_q;
    end
    if (bus.NXT_ADR && (adr_q != ADR_LAST)) begin
      adr_d = adr_q + ADR_W'(1);
    end else begin
      adr_d = adr_q;
    end
    // LOAD_PAT reads the pre-increment address; CLEAR wins over LOAD_PAT.
    if (bus.CLEAR) begin
      pat_d = '0;
    end else if (bus.LOAD_PAT) begin
      pat_d = pat_entry(adr_q);
    end else begin
      pat_d = pat_q;
    end
    led_d = bus.DISP ? pat_q : '0;
    upd_s = (led_d != led_q);
  end

  // Serial shift-out: a change while busy is remembered and resent with the latest value.
  always_comb begin
    st_d     = st_q;
    sr_d     = sr_q;
    bcnt_d   = bcnt_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    slatch_d = 1'b0;
    busy_d   = busy_q;
    if (upd_s && busy_q) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    case (st_q)
      ST_IDLE: begin
        if (upd_s || pend_q) begin
          sr_d   = led_d;
          bcnt_d = CNT_W'(LED_W);
          div_d  = '0;
          sclk_d = 1'b0;
          busy_d = 1'b1;
          pend_d = 1'b0;
          st_d   = ST_SHIFT;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            sr_d   = sr_q << 1;
            bcnt_d = bcnt_q - CNT_W'(1);
            if (bcnt_q == CNT_W'(1)) begin
              st_d     = ST_LATCH;
              slatch_d = 1'b1;
            end else begin
              st_d = ST_SHIFT;
            end
          end else begin
            sr_d = sr_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LATCH: begin
        busy_d = 1'b0;
        st_d   = ST_IDLE;
      end
      default: begin
        sclk_d = 1'b0;
        busy_d = 1'b0;
        st_d   = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transfer without a latch pulse.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      tmr_q    <= '0;
      adr_q    <= '0;
      pat_q    <= '0;
      led_q    <= '0;
      sr_q     <= '0;
      bcnt_q   <= '0;
      div_q    <= '0;
      st_q     <= ST_IDLE;
      sclk_q   <= 1'b0;
      slatch_q <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      adr_q    <= adr_d;
      pat_q    <= pat_d;
      led_q    <= led_d;
      sr_q     <= sr_d;
      bcnt_q   <= bcnt_d;
      div_q    <= div_d;
      st_q     <= st_d;
      sclk_q   <= sclk_d;
      slatch_q <= slatch_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.TMR    = tmr_q;
  assign bus.DONE   = (adr_q == ADR_LAST);
  assign bus.LED    = led_q;
  assign bus.SCLK   = sclk_q;
  assign bus.SDATA  = (st_q == ST_SHIFT) & sr_q[LED_W-1];
  assign bus.SLATCH = slatch_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_startup_display_datapath.sv
// Directed bench for startup_display_datapath with hand-computed expectations.
module tb_startup_display_datapath;

  logic clk = 1'b0;
  logic rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  startup_display_datapath_if #(.TMR_W(16), .LED_W(8)) bus ();

  startup_display_datapath #(
    .TMR_W(16), .NPAT(16), .ADR_W(4), .LED_W(8), .SCLK_DIV(4)
  ) dut (
    .CLK   (clk),
    .RST_B (rst_b),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Collect bits on SCLK rises until SLATCH; lat counts steps from the call.
  task automatic xfer_check(input string tag, input logic [7:0] exp_val, input int exp_lat);
    logic [7:0] val;
    logic       prev;
    int         lat;
    int         rises;
    val   = 8'h00;
    lat   = -1;
    rises = 0;
    prev  = bus.SCLK;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (bus.SCLK && !prev) begin
        val = {val[6:0], bus.SDATA};
        rises++;
      end
      prev = bus.SCLK;
      if (bus.SLATCH) begin
        lat = c;
        break;
      end
    end
    check_val({tag, "_data"}, 32'(val), 32'(exp_val));
    check_val({tag, "_rises"}, 32'(rises), 32'd8);
    check_val({tag, "_latch_cyc"}, 32'(lat), 32'(exp_lat));
    step();
    check_val({tag, "_slatch_1cyc"}, 32'(bus.SLATCH), 32'd0);
    check_val({tag, "_busy_drop"}, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    rst_b        = 1'b0;
    bus.CLEAR    = 1'b0;
    bus.DISP     = 1'b1;
    bus.LOAD_PAT = 1'b0;
    bus.NXT_ADR  = 1'b0;
    bus.RST_TMR  = 1'b0;
    repeat (2) step();
    check_val("rst_tmr", 32'(bus.TMR), 32'd0);
    check_val("rst_done", 32'(bus.DONE), 32'd0);
    check_val("rst_led", 32'(bus.LED), 32'd0);
    check_val("rst_sclk", 32'(bus.SCLK), 32'd0);
    check_val("rst_sdata", 32'(bus.SDATA), 32'd0);
    check_val("rst_slatch", 32'(bus.SLATCH), 32'd0);
    check_val("rst_busy", 32'(bus.BUSY), 32'd0);

    rst_b = 1'b1;
    step();
    check_val("tmr_1", 32'(bus.TMR), 32'd1);
    step();
    check_val("tmr_2", 32'(bus.TMR), 32'd2);
    step();
    check_val("tmr_3", 32'(bus.TMR), 32'd3);
    check_val("idle_led", 32'(bus.LED), 32'd0);
    check_val("idle_busy", 32'(bus.BUSY), 32'd0);

    repeat (70000) step();
    check_val("tmr_sat", 32'(bus.TMR), 32'hFFFF);
    bus.RST_TMR = 1'b1;
    step();
    bus.RST_TMR = 1'b0;
    check_val("tmr_clr", 32'(bus.TMR), 32'd0);
    step();
    check_val("tmr_restart", 32'(bus.TMR), 32'd1);

    // Load at ADR 0 with a same-cycle increment, then change LED mid-transfer.
    bus.LOAD_PAT = 1'b1;
    bus.NXT_ADR  = 1'b1;
    step();
    bus.LOAD_PAT = 1'b0;
    bus.NXT_ADR  = 1'b0;
    check_val("done_adr1", 32'(bus.DONE), 32'd0);
    fork
      xfer_check("xfer01", 8'h01, 65);
      begin
        repeat (10) step();
        bus.LOAD_PAT = 1'b1;
        step();
        bus.LOAD_PAT = 1'b0;
      end
    join
    xfer_check("xfer02", 8'h02, 65);
    check_val("led_02", 32'(bus.LED), 32'h02);

    // Abort: reset while SCLK and SDATA are both high.
    bus.NXT_ADR = 1'b1;
    step();
    bus.NXT_ADR  = 1'b0;
    bus.LOAD_PAT = 1'b1;
    step();
    bus.LOAD_PAT = 1'b0;
    repeat (45) step();
    check_val("pre_abort_sclk", 32'(bus.SCLK), 32'd1);
    check_val("pre_abort_sdata", 32'(bus.SDATA), 32'd1);
    check_val("pre_abort_busy", 32'(bus.BUSY), 32'd1);
    rst_b = 1'b0;
    #1;
    check_val("abort_sclk", 32'(bus.SCLK), 32'd0);
    check_val("abort_sdata", 32'(bus.SDATA), 32'd0);
    check_val("abort_busy", 32'(bus.BUSY), 32'd0);
    check_val("abort_led", 32'(bus.LED), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("abort_no_latch", 32'(bus.SLATCH), 32'd0);
    end
    rst_b = 1'b1;
    step();
    check_val("post_abort_busy", 32'(bus.BUSY), 32'd0);

    // ADR 2 -> walking one 8'h04 sent MSB first.
    bus.NXT_ADR = 1'b1;
    repeat (2) step();
    bus.NXT_ADR  = 1'b0;
    bus.LOAD_PAT = 1'b1;
    step();
    bus.LOAD_PAT = 1'b0;
    check_val("led_lag", 32'(bus.LED), 32'd0);
    xfer_check("xfer04", 8'h04, 65);
    check_val("led_04", 32'(bus.LED), 32'h04);

    // CLEAR beats LOAD_PAT; DISP=0 blanks a loaded pattern.
    bus.NXT_ADR = 1'b1;
    repeat (2) step();
    bus.NXT_ADR  = 1'b0;
    bus.CLEAR    = 1'b1;
    bus.LOAD_PAT = 1'b1;
    step();
    bus.CLEAR    = 1'b0;
    bus.LOAD_PAT = 1'b0;
    check_val("clr_led_lag", 32'(bus.LED), 32'h04);
    step();
    check_val("clr_led", 32'(bus.LED), 32'd0);
    xfer_check("xfer00", 8'h00, 64);
    bus.DISP     = 1'b0;
    bus.LOAD_PAT = 1'b1;
    step();
    bus.LOAD_PAT = 1'b0;
    step();
    check_val("nodisp_led", 32'(bus.LED), 32'd0);
    check_val("nodisp_busy", 32'(bus.BUSY), 32'd0);
    bus.DISP = 1'b1;
    step();
    check_val("disp_led_10", 32'(bus.LED), 32'h10);
    xfer_check("xfer10", 8'h10, 64);

    // Address saturation: ADR 4 + 10 = 14, +1 = 15 (DONE), +1 stays 15.
    bus.NXT_ADR = 1'b1;
    repeat (10) step();
    bus.NXT_ADR = 1'b0;
    check_val("done_adr14", 32'(bus.DONE), 32'd0);
    bus.NXT_ADR = 1'b1;
    step();
    bus.NXT_ADR = 1'b0;
    check_val("done_adr15", 32'(bus.DONE), 32'd1);
    bus.NXT_ADR = 1'b1;
    step();
    bus.NXT_ADR = 1'b0;
    check_val("done_sat", 32'(bus.DONE), 32'd1);
    bus.LOAD_PAT = 1'b1;
    step();
    bus.LOAD_PAT = 1'b0;
    check_val("led80_lag", 32'(bus.LED), 32'h10);
    step();
    check_val("led_80", 32'(bus.LED), 32'h80);
    xfer_check("xfer80", 8'h80, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
